// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: per-register hold vectors, FSM states
// and the MEM > EX > ID stall priority encoder.
package pipe_ctrl_pkg;

   localparam logic [5:0]  STALL_NONE = 6'b000000;
   localparam logic [5:0]  STALL_ID   = 6'b000111;
   localparam logic [5:0]  STALL_EX   = 6'b001111;
   localparam logic [5:0]  STALL_MEM  = 6'b011111;
   localparam logic [31:0] ZeroWord   = '0;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_FLUSH
   } state_e;

   function automatic logic [5:0] stall_sel(input logic req_id,
                                            input logic req_ex,
                                            input logic req_mem);
      logic [5:0] code;
      code = STALL_NONE;
      if (req_mem)
         code = STALL_MEM;
      else if (req_ex)
         code = STALL_EX;
      else if (req_id)
         code = STALL_ID;
      return code;
   endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage hold vector, one-cycle
// flush with redirect PC, total stall counter and sticky stall-run timeout.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_LIMIT = 255,
   parameter int unsigned CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_id,
   input  logic             stallreq_ex,
   input  logic             stallreq_mem,
   input  logic             excp_valid,
   input  logic [31:0]      excp_pc,
   output logic [5:0]       stall,
   output logic             flush,
   output logic [31:0]      new_pc,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             stall_timeout
);

   localparam int unsigned RUN_W = (TIMEOUT_LIMIT < 2) ? 1 : $clog2(TIMEOUT_LIMIT + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT_LIMIT);

   state_e           state_q, state_d;
   logic [31:0]      pend_pc_q, pend_pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             timeout_q, timeout_d;
   logic             stall_act;

   always_comb begin
      stall     = STALL_NONE;
      flush     = 1'b0;
      state_d   = state_q;
      pend_pc_d = pend_pc_q;

      case (state_q)
         ST_RUN: begin
            if (excp_valid) begin
               pend_pc_d = excp_pc;
               stall     = STALL_MEM;
               state_d   = stallreq_mem ? ST_DRAIN : ST_FLUSH;
            end else begin
               stall = stall_sel(stallreq_id, stallreq_ex, stallreq_mem);
            end
         end
         ST_DRAIN: begin
            stall = STALL_MEM;
            if (!stallreq_mem)
               state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            flush   = 1'b1;
            state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase

      // Reset masks the decoder so nothing is held or flushed while rst is high.
      if (rst) begin
         stall = STALL_NONE;
         flush = 1'b0;
      end

      stall_act = (stall != STALL_NONE);
      cnt_d     = (stall_act && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
      if (!stall_act)
         run_d = '0;
      else if (run_q == RUN_MAX)
         run_d = run_q;
      else
         run_d = run_q + RUN_W'(1);
      timeout_d = timeout_q | (run_q == RUN_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         pend_pc_q <= ZeroWord;
         cnt_q     <= '0;
         run_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_pc_q <= pend_pc_d;
         cnt_q     <= cnt_d;
         run_q     <= run_d;
         timeout_q <= timeout_d;
      end
   end

   assign new_pc        = pend_pc_q;
   assign stall_cnt     = cnt_q;
   assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand-written
// timeout/saturation/reset sequences, then random traffic against a model.
module tb_pipe_ctrl;

   localparam int unsigned TL   = 255;
   localparam int unsigned CW   = 8;
   localparam int unsigned CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, id, ex, mem, ev;
   logic [31:0]   epc;
   logic [5:0]    stall;
   logic          flush;
   logic [31:0]   new_pc;
   logic [CW-1:0] stall_cnt;
   logic          stall_timeout;

   always #5 clk = ~clk;

   pipe_ctrl #(.TIMEOUT_LIMIT(TL), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .stallreq_id   (id),
      .stallreq_ex   (ex),
      .stallreq_mem  (mem),
      .excp_valid    (ev),
      .excp_pc       (epc),
      .stall         (stall),
      .flush         (flush),
      .new_pc        (new_pc),
      .stall_cnt     (stall_cnt),
      .stall_timeout (stall_timeout)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: an accepted exception either waits for MEM or flushes next cycle.
   bit          m_pend, m_fl, m_to;
   logic [31:0] m_pc;
   int unsigned m_cnt, m_run;
   logic [5:0]  e_stall;
   logic        e_flush;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_eval();
      if (rst)                       begin e_stall = 6'h00; e_flush = 1'b0; end
      else if (m_fl)                 begin e_stall = 6'h00; e_flush = 1'b1; end
      else if (m_pend || ev)         begin e_stall = 6'h1F; e_flush = 1'b0; end
      else if (mem)                  begin e_stall = 6'h1F; e_flush = 1'b0; end
      else if (ex)                   begin e_stall = 6'h0F; e_flush = 1'b0; end
      else if (id)                   begin e_stall = 6'h07; e_flush = 1'b0; end
      else                           begin e_stall = 6'h00; e_flush = 1'b0; end
   endfunction

   function automatic void model_update();
      if (rst) begin
         m_pend = 0; m_fl = 0; m_to = 0; m_pc = '0; m_cnt = 0; m_run = 0;
      end else begin
         if (e_stall != 0 && m_cnt < CMAX) m_cnt++;
         if (m_run == TL) m_to = 1;
         m_run = (e_stall != 0) ? ((m_run < TL) ? m_run + 1 : TL) : 0;
         if (m_fl)
            m_fl = 0;
         else if (m_pend) begin
            if (!mem) begin m_pend = 0; m_fl = 1; end
         end else if (ev) begin
            m_pc = epc;
            if (mem) m_pend = 1; else m_fl = 1;
         end
      end
   endfunction

   task automatic apply(input logic r, i, e, m, v, input logic [31:0] pc);
      @(negedge clk);
      rst = r; id = i; ex = e; mem = m; ev = v; epc = pc;
      #1;
      model_eval();
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
   endtask

   task automatic chk_model();
      chk("m_stall", 64'(stall), 64'(e_stall));
      chk("m_flush", 64'(flush), 64'(e_flush));
      chk("m_new_pc", 64'(new_pc), 64'(m_pc));
      chk("m_cnt", 64'(stall_cnt), 64'(m_cnt));
      chk("m_timeout", 64'(stall_timeout), 64'(m_to));
   endtask

   typedef struct {
      logic r, i, e, m, v;
      logic [31:0] pc;
      logic [5:0]  st;
      logic        fl;
      logic [31:0] npc;
      int          cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mkv(logic i, e, m, v, logic [31:0] pc,
                                logic [5:0] st, logic fl, logic [31:0] npc, int cnt);
      vec_t x;
      x.r = 0; x.i = i; x.e = e; x.m = m; x.v = v; x.pc = pc;
      x.st = st; x.fl = fl; x.npc = npc; x.cnt = cnt;
      return x;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; id = 0; ex = 0; mem = 0; ev = 0; epc = '0;
      m_pend = 0; m_fl = 0; m_to = 0; m_pc = '0; m_cnt = 0; m_run = 0;
      e_stall = '0; e_flush = 0;

      // Reset, with requests asserted to show rst overrides them
      apply(1, 1, 1, 1, 1, 32'h1111_2222);
      chk("rst_stall", 64'(stall), 64'h0);
      chk("rst_flush", 64'(flush), 64'h0);
      advance();
      apply(1, 0, 0, 0, 0, 0); advance();
      apply(0, 0, 0, 0, 0, 0);
      chk("post_rst_stall", 64'(stall), 64'h0);
      chk("post_rst_new_pc", 64'(new_pc), 64'h0);
      chk("post_rst_cnt", 64'(stall_cnt), 64'h0);
      chk("post_rst_timeout", 64'(stall_timeout), 64'h0);
      advance();

      // Directed vectors: ID/EX stalls, fast exception, exception behind MEM stall
      tbl.push_back(mkv(1, 0, 0, 0, 0,            6'h07, 0, 0, 0));
      tbl.push_back(mkv(0, 1, 0, 0, 0,            6'h0F, 0, 0, 1));
      tbl.push_back(mkv(0, 1, 0, 0, 0,            6'h0F, 0, 0, 2));
      tbl.push_back(mkv(1, 1, 0, 0, 0,            6'h0F, 0, 0, 3));
      tbl.push_back(mkv(0, 0, 0, 0, 0,            6'h00, 0, 0, 4));
      tbl.push_back(mkv(1, 1, 0, 1, 32'hBFC00380, 6'h1F, 0, 0, 4));
      tbl.push_back(mkv(0, 1, 1, 1, 32'h12345678, 6'h00, 1, 32'hBFC00380, 5));
      tbl.push_back(mkv(0, 0, 0, 0, 0,            6'h00, 0, 0, 5));
      tbl.push_back(mkv(0, 0, 1, 1, 32'h80000180, 6'h1F, 0, 0, 5));
      tbl.push_back(mkv(0, 0, 1, 1, 32'hDEADBEEF, 6'h1F, 0, 0, 6));
      tbl.push_back(mkv(0, 0, 1, 0, 0,            6'h1F, 0, 0, 7));
      tbl.push_back(mkv(0, 0, 1, 1, 32'hCAFEF00D, 6'h1F, 0, 0, 8));
      tbl.push_back(mkv(1, 0, 0, 0, 0,            6'h1F, 0, 0, 9));
      tbl.push_back(mkv(1, 1, 1, 1, 32'h0BAD0BAD, 6'h00, 1, 32'h80000180, 10));
      tbl.push_back(mkv(0, 0, 0, 0, 0,            6'h00, 0, 0, 10));
      for (int k = 0; k < tbl.size(); k++) begin
         apply(tbl[k].r, tbl[k].i, tbl[k].e, tbl[k].m, tbl[k].v, tbl[k].pc);
         chk($sformatf("vec%0d_stall", k), 64'(stall), 64'(tbl[k].st));
         chk($sformatf("vec%0d_flush", k), 64'(flush), 64'(tbl[k].fl));
         if (tbl[k].fl)
            chk($sformatf("vec%0d_new_pc", k), 64'(new_pc), 64'(tbl[k].npc));
         chk($sformatf("vec%0d_cnt", k), 64'(stall_cnt), 64'(tbl[k].cnt));
         chk($sformatf("vec%0d_timeout", k), 64'(stall_timeout), 64'h0);
         advance();
      end

      // Long EX stall: timeout at the limit, stall_cnt saturates at 8'hFF
      apply(1, 0, 0, 0, 0, 0); advance();
      for (int k = 0; k < int'(TL); k++) begin
         apply(0, 0, 1, 0, 0, 0);
         if (k == int'(TL) - 1) chk("to_before_limit", 64'(stall_timeout), 64'h0);
         advance();
      end
      apply(0, 0, 0, 0, 0, 0);
      chk("to_idle_stall", 64'(stall), 64'h0);
      chk("to_cnt_full", 64'(stall_cnt), 64'hFF);
      chk("to_not_yet", 64'(stall_timeout), 64'h0);
      advance();
      for (int k = 0; k < 3; k++) begin
         apply(0, 0, 0, 0, 0, 0);
         chk($sformatf("to_sticky%0d", k), 64'(stall_timeout), 64'h1);
         advance();
      end
      for (int k = 0; k < 5; k++) begin
         apply(0, 0, 0, 1, 0, 0);
         chk($sformatf("sat_stall%0d", k), 64'(stall), 64'h1F);
         advance();
      end
      apply(0, 0, 0, 0, 0, 0);
      chk("sat_cnt", 64'(stall_cnt), 64'hFF);
      chk("sat_timeout", 64'(stall_timeout), 64'h1);
      advance();

      // Reset while draining discards the pending exception
      apply(1, 0, 0, 0, 0, 0); advance();
      apply(0, 0, 0, 1, 1, 32'hAAAA0000); advance();
      apply(0, 0, 0, 1, 0, 0);
      chk("drain_stall", 64'(stall), 64'h1F);
      advance();
      apply(1, 1, 1, 1, 1, 32'h5555_0000);
      chk("drain_rst_stall", 64'(stall), 64'h0);
      chk("drain_rst_flush", 64'(flush), 64'h0);
      advance();
      for (int k = 0; k < 4; k++) begin
         apply(0, 0, 0, 0, 0, 0);
         chk($sformatf("drain_rst_noflush%0d", k), 64'(flush), 64'h0);
         if (k == 0) begin
            chk("drain_rst_cnt", 64'(stall_cnt), 64'h0);
            chk("drain_rst_timeout", 64'(stall_timeout), 64'h0);
            chk("drain_rst_new_pc", 64'(new_pc), 64'h0);
         end
         advance();
      end

      // Random traffic against the reference model
      apply(1, 0, 0, 0, 0, 0); advance();
      for (int k = 0; k < 3000; k++) begin
         apply(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 7) == 0),
               $urandom);
         chk_model();
         advance();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
